// File: rtl/error_countdown_timer.sv
// Whole-second countdown for the control FSM's error wait state; pulses timeout at zero.
// Optional COUNTDOWN_BLINK_EN: blink toggles every half second while counting (else blink == busy).
module error_countdown_timer #(
  parameter int unsigned TICKS_PER_SEC = 100_000_000,
  parameter int unsigned DEFAULT_SEC   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] cfg_sec,
  output logic       busy,
  output logic [3:0] remain_sec,
  output logic       timeout,
  output logic       blink
);

  localparam int unsigned SEC_W = 4;
  localparam int unsigned PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);
`ifdef COUNTDOWN_BLINK_EN
  localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(TICKS_PER_SEC / 2 - 1);
`endif

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [SEC_W-1:0]   remain_q, remain_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic               blink_q, blink_d;
  logic [SEC_W-1:0]   load_val;

  assign load_val = (cfg_sec == '0) ? SEC_W'(DEFAULT_SEC) : cfg_sec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      remain_q  <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      blink_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      remain_q  <= remain_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      blink_q   <= blink_d;
    end
  end

  // Next state: abort beats start, start beats the per-second tick (even on the final tick).
  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    remain_d  = remain_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    blink_d   = blink_q;

    if (abort) begin
      state_d  = IDLE;
      pre_d    = '0;
      remain_d = '0;
      busy_d   = 1'b0;
    end else if (start) begin
      state_d  = RUN;
      pre_d    = '0;
      remain_d = load_val;
      busy_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          busy_d   = 1'b0;
          remain_d = '0;
        end
        RUN: begin
          if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (remain_q <= SEC_W'(1)) begin
              state_d   = IDLE;
              remain_d  = '0;
              busy_d    = 1'b0;
              timeout_d = 1'b1;
            end else begin
              remain_d = remain_q - SEC_W'(1);
            end
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

`ifdef COUNTDOWN_BLINK_EN
    // Prescaler doubles as the half-second phase: toggle at its midpoint and its wrap.
    if (!busy_d) begin
      blink_d = 1'b0;
    end else if (start && !abort) begin
      blink_d = 1'b1;
    end else if ((pre_q == PRE_HALF) || (pre_q == PRE_LAST)) begin
      blink_d = ~blink_q;
    end
`else
    blink_d = busy_d;
`endif
  end

  assign busy       = busy_q;
  assign remain_sec = remain_q;
  assign timeout    = timeout_q;
  assign blink      = blink_q;

endmodule

// File: tb/tb_error_countdown_timer.sv
// Directed bench for error_countdown_timer with TICKS_PER_SEC=4, DEFAULT_SEC=5.
module tb_error_countdown_timer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] cfg_sec;
  logic       busy;
  logic [3:0] remain_sec;
  logic       timeout;
  logic       blink;

  int errors = 0;
  int checks = 0;

  error_countdown_timer #(
    .TICKS_PER_SEC(4),
    .DEFAULT_SEC  (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .cfg_sec   (cfg_sec),
    .busy      (busy),
    .remain_sec(remain_sec),
    .timeout   (timeout),
    .blink     (blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       abort;
    logic [3:0] cfg;
    logic       busy;
    logic [3:0] rem;
    logic       to;
    logic       blk;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic s, input logic a, input logic [3:0] c,
                              input logic b, input logic [3:0] r, input logic t,
                              input logic k);
    vec_t v;
    v.start = s; v.abort = a; v.cfg = c;
    v.busy = b; v.rem = r; v.to = t; v.blk = k;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_blink(input string name, input logic exp_blk, input logic exp_busy);
`ifdef COUNTDOWN_BLINK_EN
    chk(name, int'(blink), int'(exp_blk));
`else
    chk(name, int'(blink), int'(exp_busy));
`endif
  endtask

  initial begin
    int seen;

    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_sec = 4'd0;

    // Test 1: cfg_sec=3, cfg_sec changed mid-run must be ignored.
    add(1,0,4'd3, 1,4'd3,0,1);  // e0
    add(0,0,4'd3, 1,4'd3,0,1);
    add(0,0,4'd3, 1,4'd3,0,0);
    add(0,0,4'd3, 1,4'd3,0,0);
    add(0,0,4'd3, 1,4'd2,0,1);  // e4
    add(0,0,4'd7, 1,4'd2,0,1);
    add(0,0,4'd7, 1,4'd2,0,0);
    add(0,0,4'd3, 1,4'd2,0,0);
    add(0,0,4'd3, 1,4'd1,0,1);  // e8
    add(0,0,4'd3, 1,4'd1,0,1);
    add(0,0,4'd3, 1,4'd1,0,0);
    add(0,0,4'd3, 1,4'd1,0,0);
    add(0,0,4'd3, 0,4'd0,1,0);  // e12 timeout
    add(0,0,4'd3, 0,4'd0,0,0);
    // Test 4 + blink pattern: cfg_sec=2, restart on final-tick edge with cfg_sec=1.
    add(1,0,4'd2, 1,4'd2,0,1);  // e0
    add(0,0,4'd2, 1,4'd2,0,1);
    add(0,0,4'd2, 1,4'd2,0,0);
    add(0,0,4'd2, 1,4'd2,0,0);
    add(0,0,4'd2, 1,4'd1,0,1);  // e4
    add(0,0,4'd2, 1,4'd1,0,1);
    add(0,0,4'd2, 1,4'd1,0,0);
    add(0,0,4'd2, 1,4'd1,0,0);
    add(1,0,4'd1, 1,4'd1,0,1);  // e8 restart
    add(0,0,4'd1, 1,4'd1,0,1);
    add(0,0,4'd1, 1,4'd1,0,0);
    add(0,0,4'd1, 1,4'd1,0,0);
    add(0,0,4'd1, 0,4'd0,1,0);  // e12 timeout
    add(0,0,4'd1, 0,4'd0,0,0);
    // Test 5a: start with abort same cycle, then abort while idle.
    add(1,1,4'd3, 0,4'd0,0,0);
    add(0,0,4'd3, 0,4'd0,0,0);
    add(0,0,4'd3, 0,4'd0,0,0);
    add(0,1,4'd3, 0,4'd0,0,0);
    add(0,0,4'd3, 0,4'd0,0,0);

    // Reset state
    step(); step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_remain", int'(remain_sec), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_blink", int'(blink), 0);
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      start = vecs[i].start; abort = vecs[i].abort; cfg_sec = vecs[i].cfg;
      step();
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].busy));
      chk($sformatf("vec%0d_remain", i), int'(remain_sec), int'(vecs[i].rem));
      chk($sformatf("vec%0d_timeout", i), int'(timeout), int'(vecs[i].to));
      chk_blink($sformatf("vec%0d_blink", i), vecs[i].blk, vecs[i].busy);
    end
    start = 1'b0; abort = 1'b0;

    // Test 2: cfg_sec=0 loads DEFAULT_SEC; timeout after edge 20.
    start = 1'b1; cfg_sec = 4'd0;
    step();
    start = 1'b0; cfg_sec = 4'd9;
    chk("t2_remain_e0", int'(remain_sec), 5);
    chk("t2_busy_e0", int'(busy), 1);
    for (int i = 1; i <= 24; i++) begin
      step();
      chk($sformatf("t2_timeout_e%0d", i), int'(timeout), int'(i == 20));
      if (i == 4)  chk("t2_remain_e4", int'(remain_sec), 4);
      if (i == 19) chk("t2_remain_e19", int'(remain_sec), 1);
      if (i == 20) chk("t2_busy_e20", int'(busy), 0);
    end

    // Test 3: abort at edge 6 of a 3 s run.
    start = 1'b1; cfg_sec = 4'd3;
    step();
    start = 1'b0;
    repeat (5) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t3_busy", int'(busy), 0);
    chk("t3_remain", int'(remain_sec), 0);
    chk_blink("t3_blink", 1'b0, 1'b0);
    seen = 0;
    repeat (40) begin
      step();
      if (timeout) seen = 1;
    end
    chk("t3_no_timeout", seen, 0);

    // Test 5b: rst at edge 5 of a run.
    start = 1'b1; cfg_sec = 4'd4;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("t5_busy_pre_rst", int'(busy), 1);
    rst = 1'b1;
    step();
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_remain", int'(remain_sec), 0);
    chk("t5_rst_timeout", int'(timeout), 0);
    chk("t5_rst_blink", int'(blink), 0);
    rst = 1'b0;
    seen = 0;
    repeat (25) begin
      step();
      if (timeout || busy) seen = 1;
    end
    chk("t5_stays_idle", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
